// File: rtl/alu_shift_sequencer.sv
// Multi-pass ALU sequencer: captures operands on Start and repeatedly feeds
// the accumulator back through one ALU until the pass count is exhausted.

module alu_module (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [31:0] y_o
);
    // single combinational pass; nop and illegal codes produce zero
    always_comb begin
        y_o = 32'd0;
        case (op_i)
            4'b0000: y_o = a_i + b_i;
            4'b0001: y_o = a_i - b_i;
            4'b0010: y_o = a_i & b_i;
            4'b0011: y_o = a_i | b_i;
            4'b0100: y_o = ~a_i;
            4'b1000: y_o = {a_i[31], a_i[31:1]};
            4'b1001: y_o = {a_i[30:0], 1'b0};
            4'b1010: y_o = {1'b0, a_i[31:1]};
            4'b1100: y_o = {a_i[30:0], a_i[31]};
            4'b1101: y_o = {a_i[0], a_i[31:1]};
            default: y_o = 32'd0;
        endcase
    end
endmodule

module alu_shift_sequencer (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  Op,
    input  logic [4:0]  Amt,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Out,
    output logic        Zero,
    output logic        Err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: is_shift = 1'b1;
            default:                                      is_shift = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1111: is_legal = 1'b1;
            default:                                              is_legal = is_shift(op);
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] out_q, out_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic [31:0] alu_y_s;
    logic        legal_s;

    alu_module u_alu (
        .a_i  (acc_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y_s)
    );

    assign legal_s = is_legal(Op);

    // next-state and result computation; result registers change only on entry to DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d  = A;
                    b_d    = B;
                    op_d   = Op;
                    busy_d = 1'b1;
                    if (is_shift(Op)) begin
                        cnt_d = Amt;
                    end else if (legal_s) begin
                        cnt_d = 5'd1;
                    end else begin
                        cnt_d = 5'd0;
                    end
                    if (cnt_d != 5'd0) begin
                        state_d = S_RUN;
                    end else begin
                        // zero passes: result is A, or 0 flagged as error for illegal codes
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        out_d   = legal_s ? A : 32'd0;
                        zero_d  = (out_d == 32'd0);
                        err_d   = ~legal_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = alu_y_s;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    out_d   = alu_y_s;
                    zero_d  = (alu_y_s == 32'd0);
                    err_d   = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 32'd0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Out  = out_q;
    assign Zero = zero_q;
    assign Err  = err_q;
endmodule
